// File: rtl/pong_gfx_pkg.sv
// Shared sprite types, separator defaults and priority encoder for the compositor.
// Width defaults come from X_POS_W / Y_POS_W / VGA_RGB_W / SCREEN_H_RES when not predefined.
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif
`ifndef VGA_RGB_W
`define VGA_RGB_W 12
`endif
`ifndef SCREEN_H_RES
`define SCREEN_H_RES 640
`endif

package pong_gfx_pkg;
    localparam int SPR_X_W    = `X_POS_W;
    localparam int SPR_Y_W    = `Y_POS_W;
    localparam int SPR_SIZE_W = 7;
    localparam int SPR_RGB_W  = `VGA_RGB_W;
    localparam int SCR_H_RES  = `SCREEN_H_RES;

    localparam int SEP_W_DEF      = 4;
    localparam int SEP_DOT_H_DEF  = 16;
    localparam int SEP_PERIOD_DEF = 32;
    localparam int SEP_OFFSET_DEF = 9;

    typedef struct packed {
        logic [SPR_X_W-1:0]    x;
        logic [SPR_Y_W-1:0]    y;
        logic [SPR_SIZE_W-1:0] w;
        logic [SPR_SIZE_W-1:0] h;
        logic [SPR_RGB_W-1:0]  rgb;
        logic                  en;
    } sprite_t;

    // Lowest set bit wins; returns 0 for an empty vector.
    function automatic logic [3:0] prio_enc(input logic [15:0] v);
        prio_enc = '0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) prio_enc = 4'(i);
    endfunction
endpackage

// File: rtl/sprite_hit.sv
// Combinational rectangle hit test for one sprite; extents computed one bit wider so edges clip.
module sprite_hit
    import pong_gfx_pkg::*;
(
    input  sprite_t              spr,
    input  logic [SPR_X_W-1:0]   x,
    input  logic [SPR_Y_W-1:0]   y,
    output logic                 hit
);
    logic [SPR_X_W:0] x_end;
    logic [SPR_Y_W:0] y_end;
    logic             unused_rgb;

    assign x_end      = {1'b0, spr.x} + (SPR_X_W+1)'(spr.w);
    assign y_end      = {1'b0, spr.y} + (SPR_Y_W+1)'(spr.h);
    assign unused_rgb = ^spr.rgb;

    assign hit = spr.en
              && (x >= spr.x) && ({1'b0, x} < x_end)
              && (y >= spr.y) && ({1'b0, y} < y_end);
endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite/separator compositor with double-buffered sprite slots.
// Optional per-sprite overlap reporting is built when SPRITE_COLLISION_EN is defined.
module sprite_compositor
    import pong_gfx_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int X_W         = SPR_X_W,
    parameter int Y_W         = SPR_Y_W,
    parameter int SIZE_W      = SPR_SIZE_W,
    parameter int RGB_W       = SPR_RGB_W,
    parameter int H_RES       = SCR_H_RES,
    parameter int SEP_W       = SEP_W_DEF,
    parameter int SEP_DOT_H   = SEP_DOT_H_DEF,
    parameter int SEP_PERIOD  = SEP_PERIOD_DEF,
    parameter int SEP_OFFSET  = SEP_OFFSET_DEF,
    localparam int IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [X_W-1:0]         vga_x_pos_i,
    input  logic [Y_W-1:0]         vga_y_pos_i,
    input  logic                   vga_visible_range_i,
    input  logic                   frame_start_i,
    input  logic                   spr_we_i,
    input  logic [IDX_W-1:0]       spr_idx_i,
    input  logic [X_W-1:0]         spr_x_i,
    input  logic [Y_W-1:0]         spr_y_i,
    input  logic [SIZE_W-1:0]      spr_w_i,
    input  logic [SIZE_W-1:0]      spr_h_i,
    input  logic [RGB_W-1:0]       spr_rgb_i,
    input  logic                   spr_en_i,
    input  logic                   sep_en_i,
    output logic [RGB_W-1:0]       vga_rgb_o,
    output logic                   vga_visible_o,
    output logic [NUM_SPRITES-1:0] collision_o,
    output logic                   collision_valid_o
);
    localparam logic [X_W:0] SEP_LO = (X_W+1)'(H_RES/2 - SEP_W/2);
    localparam logic [X_W:0] SEP_HI = (X_W+1)'(H_RES/2 + SEP_W/2);

    sprite_t                shadow [NUM_SPRITES];
    sprite_t                active [NUM_SPRITES];
    sprite_t                wr_spr;
    logic                   wr_ok;
    logic [NUM_SPRITES-1:0] hit;
    logic [15:0]            hit16;
    logic [3:0]             win;
    logic [RGB_W-1:0]       win_rgb;
    logic [Y_W:0]           sep_row;
    logic                   sep_hit;

    logic [1:0]             vis_pipe;
    logic [NUM_SPRITES-1:0] s1_hit;
    logic                   s1_sep;
    logic [RGB_W-1:0]       s1_rgb;

    assign wr_spr = '{x: spr_x_i, y: spr_y_i, w: spr_w_i, h: spr_h_i, rgb: spr_rgb_i, en: spr_en_i};
    assign wr_ok  = spr_we_i && ({1'b0, spr_idx_i} < (IDX_W+1)'(NUM_SPRITES));

    // A write landing on the commit cycle goes straight through to the active bank.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (wr_ok && spr_idx_i == IDX_W'(i))
                    shadow[i] <= wr_spr;
                if (frame_start_i)
                    active[i] <= (wr_ok && spr_idx_i == IDX_W'(i)) ? wr_spr : shadow[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit u_hit (.spr(active[g]), .x(vga_x_pos_i), .y(vga_y_pos_i), .hit(hit[g]));
    end

    // Winner colour is captured in stage 1 so a commit cannot change an in-flight pixel.
    always_comb begin
        hit16                  = '0;
        hit16[NUM_SPRITES-1:0] = hit;
        win                    = prio_enc(hit16);
        win_rgb                = '0;
        for (int i = 0; i < NUM_SPRITES; i++)
            if (4'(i) == win) win_rgb = active[i].rgb;
    end

    assign sep_row = ({1'b0, vga_y_pos_i} + (Y_W+1)'(SEP_OFFSET)) & (Y_W+1)'(SEP_PERIOD-1);
    assign sep_hit = sep_en_i
                  && ({1'b0, vga_x_pos_i} > SEP_LO) && ({1'b0, vga_x_pos_i} < SEP_HI)
                  && (sep_row < (Y_W+1)'(SEP_DOT_H));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vis_pipe  <= '0;
            s1_hit    <= '0;
            s1_sep    <= 1'b0;
            s1_rgb    <= '0;
            vga_rgb_o <= '0;
        end else begin
            vis_pipe <= {vis_pipe[0], vga_visible_range_i};
            s1_hit   <= hit;
            s1_sep   <= sep_hit;
            s1_rgb   <= win_rgb;
            if (!vis_pipe[0])   vga_rgb_o <= '0;
            else if (s1_sep)    vga_rgb_o <= '1;
            else if (|s1_hit)   vga_rgb_o <= s1_rgb;
            else                vga_rgb_o <= '0;
        end
    end

    assign vga_visible_o = vis_pipe[1];

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] acc;
    logic [NUM_SPRITES-1:0] coll_new;
    logic [NUM_SPRITES-1:0] coll_q;
    logic                   coll_v;

    always_comb begin
        coll_new = '0;
        for (int i = 0; i < NUM_SPRITES; i++)
            coll_new[i] = vis_pipe[0] && s1_hit[i]
                       && |(s1_hit & ~(NUM_SPRITES'(1) << i));
    end

    // Overlaps seen on the commit cycle belong to the frame that is starting.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc    <= '0;
            coll_q <= '0;
            coll_v <= 1'b0;
        end else begin
            coll_v <= frame_start_i;
            if (frame_start_i) begin
                coll_q <= acc;
                acc    <= coll_new;
            end else begin
                acc    <= acc | coll_new;
            end
        end
    end

    assign collision_o       = coll_q;
    assign collision_valid_o = coll_v;
`else
    assign collision_o       = '0;
    assign collision_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed, table-driven bench for sprite_compositor (default 4 slots, 640-wide, 10-bit x/y, 12-bit rgb).
module tb_sprite_compositor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x_pos = '0, y_pos = '0;
    logic        vis = 1'b0, fs = 1'b0, we = 1'b0, sep = 1'b0, s_en = 1'b0;
    logic [1:0]  idx = '0;
    logic [9:0]  s_x = '0, s_y = '0;
    logic [6:0]  s_w = '0, s_h = '0;
    logic [11:0] s_rgb = '0;
    logic [11:0] rgb;
    logic        vis_o, cv;
    logic [3:0]  coll;

`ifdef SPRITE_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int x; int y; bit v; bit s; int e;
    } vec_t;
    vec_t vt [22];

    always #5 clk = ~clk;

    sprite_compositor dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .vga_x_pos_i(x_pos), .vga_y_pos_i(y_pos), .vga_visible_range_i(vis),
        .frame_start_i(fs), .spr_we_i(we), .spr_idx_i(idx),
        .spr_x_i(s_x), .spr_y_i(s_y), .spr_w_i(s_w), .spr_h_i(s_h),
        .spr_rgb_i(s_rgb), .spr_en_i(s_en), .sep_en_i(sep),
        .vga_rgb_o(rgb), .vga_visible_o(vis_o),
        .collision_o(coll), .collision_valid_o(cv)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wr(input int i, input int x, input int y, input int w, input int h,
                      input int c, input bit en);
        we = 1'b1; idx = 2'(i); s_x = 10'(x); s_y = 10'(y);
        s_w = 7'(w); s_h = 7'(h); s_rgb = 12'(c); s_en = en;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic pix(input string name, input int x, input int y, input bit v, input bit s,
                       input int e);
        x_pos = 10'(x); y_pos = 10'(y); vis = v; sep = s;
        @(posedge clk); @(posedge clk); #1;
        chk(name, int'(rgb), e);
        chk({name, "_vis"}, int'(vis_o), int'(v));
        vis = 1'b0; sep = 1'b0;
    endtask

    task automatic frame(input string name, input int exp_coll);
        fs = 1'b1;
        @(posedge clk); #1;
        fs = 1'b0;
        chk({name, "_cv"}, int'(cv), int'(COLL_EN));
        chk({name, "_coll"}, int'(coll), COLL_EN ? exp_coll : 0);
        @(posedge clk); #1;
        chk({name, "_cv_drop"}, int'(cv), 0);
    endtask

    function automatic vec_t mk(input int x, input int y, input bit v, input bit s, input int e);
        mk.x = x; mk.y = y; mk.v = v; mk.s = s; mk.e = e;
    endfunction

    initial begin
        // Separator lit columns 319..321; lit rows where (y+9)%32 < 16.
        vt[0]  = mk(320,   5, 1, 1, 'hFFF);
        vt[1]  = mk(319,   5, 1, 1, 'hFFF);
        vt[2]  = mk(321,   5, 1, 1, 'hFFF);
        vt[3]  = mk(318,   5, 1, 1, 'hABC);
        vt[4]  = mk(322,   5, 1, 1, 'hABC);
        vt[5]  = mk(320,   6, 1, 1, 'hFFF);
        vt[6]  = mk(320,   7, 1, 1, 'hABC);
        vt[7]  = mk(320,  23, 1, 1, 'hFFF);
        vt[8]  = mk(320,  22, 1, 1, 'hABC);
        vt[9]  = mk(320,   5, 1, 0, 'hABC);
        vt[10] = mk(320,   5, 0, 1, 'h000);
        vt[11] = mk(500,   5, 1, 1, 'h000);
        vt[12] = mk(1020, 300, 1, 0, 'h123);
        vt[13] = mk(1023, 300, 1, 0, 'h123);
        vt[14] = mk(1019, 300, 1, 0, 'h000);
        vt[15] = mk(0,   300, 1, 0, 'h000);
        vt[16] = mk(3,   300, 1, 0, 'h000);
        vt[17] = mk(1023, 304, 1, 0, 'h000);
        vt[18] = mk(200, 200, 1, 1, 'h0F0);
        vt[19] = mk(200, 200, 0, 0, 'h000);
        vt[20] = mk(204, 204, 1, 0, 'h0F0);
        vt[21] = mk(205, 205, 1, 0, 'h00F);

        #12;
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_vis", int'(vis_o), 0);
        chk("rst_coll", int'(coll), 0);
        chk("rst_cv", int'(cv), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        frame("fs_empty", 0);
        pix("empty_100_50", 100, 50, 1, 0, 0);
        pix("empty_0_0", 0, 0, 1, 0, 0);

        wr(0, 100, 50, 8, 40, 'hF00, 1'b1);
        pix("precommit", 100, 50, 1, 0, 0);
        frame("fs_s0", 0);
        pix("s0_tl", 100, 50, 1, 0, 'hF00);
        pix("s0_br", 107, 89, 1, 0, 'hF00);
        pix("s0_right", 108, 50, 1, 0, 0);
        pix("s0_left", 99, 50, 1, 0, 0);
        pix("s0_below", 100, 90, 1, 0, 0);

        wr(0, 195, 195, 10, 10, 'h0F0, 1'b1);
        wr(2, 198, 198, 10, 10, 'h00F, 1'b1);
        frame("fs_ovl", 0);
        pix("prio_200", 200, 200, 1, 0, 'h0F0);
        pix("s2_only", 206, 206, 1, 0, 'h00F);
        wr(1, 1020, 300, 8, 4, 'h123, 1'b1);
        wr(3, 300, 0, 64, 40, 'hABC, 1'b1);
        wr(3, 0, 0, 0, 0, 'h555, 1'b1);
        wr(3, 300, 0, 64, 40, 'hABC, 1'b1);
        frame("fs_coll", 'b0101);

        for (int i = 0; i < 22; i++)
            pix($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].v, vt[i].s, vt[i].e);

        // Back-to-back pixels: one result per clock, two cycles behind.
        x_pos = 10'd200; y_pos = 10'd200; vis = 1'b1;
        @(posedge clk); #1;
        x_pos = 10'd1021; y_pos = 10'd300;
        @(posedge clk); #1;
        chk("pipe0", int'(rgb), 'h0F0);
        x_pos = 10'd0; y_pos = 10'd0;
        @(posedge clk); #1;
        chk("pipe1", int'(rgb), 'h123);
        vis = 1'b0;
        @(posedge clk); #1;
        chk("pipe2", int'(rgb), 0);

        wr(2, 198, 198, 0, 10, 'h00F, 1'b1);

        // Slot 3 written on the commit cycle; the pixel sampled that cycle still sees the old bank.
        we = 1'b1; idx = 2'd3; s_x = 10'd50; s_y = 10'd60; s_w = 7'd5; s_h = 7'd5;
        s_rgb = 12'h777; s_en = 1'b1; fs = 1'b1;
        x_pos = 10'd320; y_pos = 10'd5; vis = 1'b1; sep = 1'b0;
        @(posedge clk); #1;
        we = 1'b0; fs = 1'b0; x_pos = 10'd50; y_pos = 10'd60;
        chk("wt_cv", int'(cv), int'(COLL_EN));
        chk("wt_coll", int'(coll), COLL_EN ? 'b0101 : 0);
        @(posedge clk); #1;
        chk("wt_old_bank", int'(rgb), 'hABC);
        vis = 1'b0;
        @(posedge clk); #1;
        chk("wt_new_bank", int'(rgb), 'h777);

        pix("w0_nohit", 206, 206, 1, 0, 0);
        pix("s3_gone", 320, 5, 1, 0, 0);
        pix("s1_kept", 1020, 300, 1, 0, 'h123);

        x_pos = 10'd50; y_pos = 10'd60; vis = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst", int'(rgb), 'h777);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rgb", int'(rgb), 0);
        chk("midrst_vis", int'(vis_o), 0);
        chk("midrst_coll", int'(coll), 0);
        @(negedge clk) rst_n = 1'b1;
        vis = 1'b0;
        pix("post_rst", 50, 60, 1, 0, 0);
        frame("fs_post_rst", 0);
        pix("post_rst_fs", 50, 60, 1, 0, 0);
        pix("post_rst_s1", 1020, 300, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
